// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequencer for an 8x8 multiplier built from one shared 4x4 multiplier. Over
// four CALC cycles it steps the operand nibble muxes through the four nibble
// pairs. It accumulates each partial product pp_in, shifted by its weight,
// into a 16-bit product register.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   request a multiply; only honoured in IDLE
//   pp_in      in   8   4x4 partial product of the currently selected nibbles
//   mux_sel_a  out  1   operand A nibble select (0 = A[3:0], 1 = A[7:4])
//   mux_sel_b  out  1   operand B nibble select (0 = B[3:0], 1 = B[7:4])
//   shift_sel  out  2   weight of pp_in (00 = x1, 01 = x16, 10 = x256)
//   busy       out  1   high in CALC and DONE
//   done       out  1   one-cycle completion pulse (DONE state)
//   product    out  16  accumulated result, held until the next accepted start
// -----------------------------------------------------------------------------
module mult_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pp_in,
    output logic        mux_sel_a,
    output logic        mux_sel_b,
    output logic [1:0]  shift_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic [3:0]  sel_q, sel_d;        // {mux_sel_a, mux_sel_b, shift_sel}
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] pp_shifted_s;

    // Nibble selects and weight for each step: lo*lo, lo(A)*hi(B), hi(A)*lo(B), hi*hi.
    function automatic logic [3:0] calc_sel(input logic [1:0] cnt);
        logic [3:0] sel;
        case (cnt)
            2'd0:    sel = 4'b0000;
            2'd1:    sel = 4'b0101;
            2'd2:    sel = 4'b1001;
            2'd3:    sel = 4'b1110;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Weight the partial product by the shift currently presented on shift_sel.
    always_comb begin
        pp_shifted_s = 16'd0;
        case (sel_q[1:0])
            2'b00:   pp_shifted_s = {8'd0, pp_in};
            2'b01:   pp_shifted_s = {4'd0, pp_in, 4'd0};
            2'b10:   pp_shifted_s = {pp_in, 8'd0};
            default: pp_shifted_s = 16'd0;
        endcase
    end

    // Next-state logic; outputs are decoded from the next state so that they
    // are registered and line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CALC;
                    cnt_d     = 2'd0;
                    product_d = 16'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CALC: begin
                product_d = product_q + pp_shifted_s;
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        if (state_d == ST_CALC) begin
            sel_d = calc_sel(cnt_d);
        end else begin
            sel_d = 4'b0000;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset overrides everything, including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            product_q <= 16'd0;
            sel_q     <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mux_sel_a = sel_q[3];
    assign mux_sel_b = sel_q[2];
    assign shift_sel = sel_q[1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Ports SHALL be listed clock and reset first, as given in REQ-002 to REQ-010; reset SHALL be synchronous and active-high, on a single clock domain.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin an 8x8 multiply; sampled only in IDLE.
REQ-005 pp_in  input  8  4x4 partial product computed combinationally from the currently selected nibbles.
REQ-006 mux_sel_a  output  1  nibble select for operand A nibble mux; 0=A[3:0], 1=A[7:4].
REQ-007 mux_sel_b  output  1  nibble select for operand B nibble mux; 0=B[3:0], 1=B[7:4].
REQ-008 shift_sel  output  2  weight of current partial product; 00=x1, 01=x16, 10=x256, 11 unused.
REQ-009 busy, done  output  1 each  busy=multiply in progress; done=one-cycle completion pulse.
REQ-010 product  output  16  accumulated 16-bit result.

Function
REQ-011 FSM SHALL have states IDLE, CALC, DONE plus a 2-bit step counter cnt used in CALC.
REQ-012 IDLE with start=1 SHALL go to CALC with cnt=0 and product cleared to 0 on the same edge; IDLE with start=0 SHALL stay in IDLE with product held.
REQ-013 In CALC, outputs SHALL be decoded from cnt: cnt0 -> sel_a=0,sel_b=0,shift=00; cnt1 -> 0,1,01; cnt2 -> 1,0,01; cnt3 -> 1,1,10.
REQ-014 Each CALC edge SHALL update product <= product + ({8'b0,pp_in} shifted left by 0/4/8 per shift_sel), truncated to 16 bits (no overflow is possible for 8x8 operands), then increment cnt.
REQ-015 CALC with cnt=3 SHALL go to DONE after its accumulate edge; cnt SHALL wrap to 0.
REQ-016 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-017 busy SHALL be 1 in CALC and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-018 Latency: start sampled at edge N -> CALC during cycles N+1..N+4 -> done=1 in cycle N+5; product SHALL be final from cycle N+5 and held until the next accepted start.
REQ-019 start while busy=1 (including in DONE) SHALL be ignored and not queued.
REQ-020 Outside CALC, mux_sel_a, mux_sel_b and shift_sel SHALL be 0.
REQ-021 pp_in SHALL be ignored outside CALC.

Reset
REQ-022 reset=1 at any edge, including mid-CALC or in DONE, SHALL force state=IDLE, cnt=0, product=0, busy=0, done=0, mux_sel_a=0, mux_sel_b=0, shift_sel=00, overriding start.
REQ-023 After reset deassertion, the first start SHALL be accepted normally.

Verification
REQ-024 The bench SHALL model the nibble muxes plus a 4x4 multiplier driving pp_in from mux_sel_a/mux_sel_b, and SHALL cover the scenarios in REQ-025 to REQ-029.
REQ-025 A=0xFF, B=0xFF, start pulse -> selects sequence (0,0,00),(0,1,01),(1,0,01),(1,1,10) in cycles N+1..N+4; done in cycle N+5; product=0xFE01.
REQ-026 A=0x12, B=0x34 -> product=0x03A8 at done; A=0x00, B=0xAB -> product=0x0000; result held for 10 idle cycles.
REQ-027 start held high through the whole operation -> exactly one done pulse per 6-cycle period (IDLE accept, 4xCALC, DONE), and no restart during busy.
REQ-028 reset asserted at cycle N+3 of an A=0xFF, B=0xFF multiply -> next cycle busy=0, product=0, selects=0; a new A=0x0F, B=0x0F start -> product=0x00E1.
REQ-029 Back-to-back: start in the cycle after done (IDLE) with A=0x80, B=0x02 -> accepted, product cleared then 0x0100 at done; the prior result is not added in.
